// File: rtl/int_cal_pkg.sv
// Shared constants, FSM state type and the pattern helper for the
// interpolator calibration self-test.
package int_cal_pkg;

  localparam int WIDTH  = 16;
  localparam int CODE_W = 4;
  localparam int LAT    = 5;
  localparam int WAIT_W = 4;

  localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(WIDTH - 1);
  localparam logic [CODE_W:0]   ERR_MAX   = (CODE_W + 1)'(WIDTH);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Bits [code:0] set, optionally rotated left by code (ones count preserved).
  function automatic logic [WIDTH-1:0] therm_pat(input logic [CODE_W-1:0] code,
                                                  input logic rot);
    logic [WIDTH-1:0]   ones;
    logic [WIDTH-1:0]   base;
    logic [2*WIDTH-1:0] dbl;
    ones = '1;
    base = ~((ones << code) << 1'b1);
    dbl  = {base, base} << code;
    if (rot) begin
      return dbl[2*WIDTH-1 -: WIDTH];
    end else begin
      return base;
    end
  endfunction

endpackage

// File: rtl/int_pat_gen.sv
// Bus driver for the popcount stage: captures a new pattern when a code is
// being driven and holds it until the next load or clear.
module int_pat_gen
  import int_cal_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [CODE_W-1:0] code,
  input  logic              rot,
  output logic [WIDTH-1:0]  pat
);

  // pattern register
  always_ff @(posedge clk) begin
    if (rst) begin
      pat <= '0;
    end else if (clr) begin
      pat <= '0;
    end else if (load) begin
      pat <= therm_pat(code, rot);
    end else begin
      pat <= pat;
    end
  end

endmodule

// File: rtl/int_cal_bist.sv
// Self-test initiator: sweeps every fine code through the popcount stage and
// scores the returned codes. All outputs are registered from next-state values.
module int_cal_bist
  import int_cal_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rot_mode,
  input  logic [CODE_W-1:0] int_data,
  output logic [WIDTH-1:0]  int_o,
  output logic              cal_en_o,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CODE_W:0]   err_cnt,
  output logic [CODE_W-1:0] first_err_code,
  output logic              first_err_vld
);

  state_t              state_r, state_s;
  logic [CODE_W-1:0]   code_r, code_s;
  logic [WAIT_W-1:0]   wait_r, wait_s;
  logic                mode_r, mode_s;
  logic [CODE_W:0]     err_s;
  logic [CODE_W-1:0]   fec_s;
  logic                fev_s;
  logic                load_s, clr_s;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) state_s = DRIVE;
        else       state_s = state_r;
      end
      DRIVE: state_s = WAIT;
      WAIT: begin
        if (wait_r == '0) state_s = CHECK;
        else              state_s = WAIT;
      end
      CHECK: begin
        if (code_r == LAST_CODE) state_s = DONE;
        else                     state_s = DRIVE;
      end
      default: state_s = IDLE;
    endcase
  end

  // datapath and scoreboard next values
  always_comb begin
    code_s = code_r;
    wait_s = wait_r;
    mode_s = mode_r;
    err_s  = err_cnt;
    fec_s  = first_err_code;
    fev_s  = first_err_vld;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          code_s = '0;
          mode_s = rot_mode;
          err_s  = '0;
          fec_s  = '0;
          fev_s  = 1'b0;
        end else begin
          code_s = code_r;
        end
      end
      DRIVE: wait_s = WAIT_INIT;
      WAIT: begin
        if (wait_r != '0) wait_s = wait_r - 1'b1;
        else              wait_s = wait_r;
      end
      CHECK: begin
        if (int_data != code_r) begin
          if (err_cnt != ERR_MAX) err_s = err_cnt + 1'b1;
          else                    err_s = err_cnt;
          if (!first_err_vld) begin
            fec_s = code_r;
            fev_s = 1'b1;
          end else begin
            fev_s = first_err_vld;
          end
        end else begin
          err_s = err_cnt;
        end
        if (code_r != LAST_CODE) code_s = code_r + 1'b1;
        else                     code_s = code_r;
      end
      default: code_s = '0;
    endcase
    load_s = (state_s == DRIVE);
    clr_s  = (state_s == IDLE) || (state_s == DONE);
  end

  // output and working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      code_r         <= '0;
      wait_r         <= '0;
      mode_r         <= 1'b0;
      err_cnt        <= '0;
      first_err_code <= '0;
      first_err_vld  <= 1'b0;
      cal_en_o       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      code_r         <= code_s;
      wait_r         <= wait_s;
      mode_r         <= mode_s;
      err_cnt        <= err_s;
      first_err_code <= fec_s;
      first_err_vld  <= fev_s;
      cal_en_o       <= (state_s == DRIVE);
      busy           <= (state_s == DRIVE) || (state_s == WAIT) || (state_s == CHECK);
      done           <= (state_s == DONE);
      pass           <= (state_s == DONE) && (err_s == '0);
    end
  end

  int_pat_gen u_pat (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .clr  (clr_s),
    .code (code_s),
    .rot  (mode_s),
    .pat  (int_o)
  );

endmodule

// File: tb/tb_int_cal_bist.sv
// Bench for int_cal_bist: a configurable popcount responder with LAT-deep
// pipeline, table-driven and randomized sweeps checked against a reference model.
module tb_int_cal_bist;
  import int_cal_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              rot_mode;
  logic [CODE_W-1:0] int_data;
  logic [WIDTH-1:0]  int_o;
  logic              cal_en_o, busy, done, pass, first_err_vld;
  logic [CODE_W:0]   err_cnt;
  logic [CODE_W-1:0] first_err_code;

  int vecs = 0;
  int errs = 0;

  logic        stuck;
  logic [15:0] fmask;
  logic [3:0]  pipe [LAT];

  always #5 clk = ~clk;

  int_cal_bist dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .rot_mode       (rot_mode),
    .int_data       (int_data),
    .int_o          (int_o),
    .cal_en_o       (cal_en_o),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_err_code (first_err_code),
    .first_err_vld  (first_err_vld)
  );

  // Faulty-or-ideal answer for a given expected code.
  function automatic logic [3:0] answer(input int k);
    if (stuck) return 4'd0;
    if (fmask[k]) return 4'((k + 2) % 16);
    return 4'(k);
  endfunction

  function automatic logic [3:0] resp(input logic [15:0] bus);
    if (bus == 16'd0) return 4'd0;
    return answer($countones(bus) - 1);
  endfunction

  always @(posedge clk) begin
    pipe[0] <= resp(int_o);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign int_data = pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_pat(input int k, input bit rot);
    logic [31:0] p;
    p = (32'd1 << (k + 1)) - 32'd1;
    if (rot && k > 0) p = ((p << k) | (p >> (16 - k))) & 32'hFFFF;
    return p;
  endfunction

  task automatic run_sweep(input bit rot, input bit stk, input logic [15:0] msk,
                           input int extra_at);
    int n, pulses, e_err, e_fec;
    bit e_fev;
    logic [15:0] held;
    stuck = stk; fmask = msk; rot_mode = rot; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rot_mode = ~rot;
    n = 0; pulses = 0; held = '0;
    chk("start_busy", busy, 1);
    chk("start_clr_done", done, 0);
    chk("start_clr_err", err_cnt, 0);
    chk("start_clr_fev", first_err_vld, 0);
    chk("start_clr_pass", pass, 0);
    while (!done && n < 300) begin
      if (cal_en_o) begin
        chk("cal_en_time", n, (LAT + 2) * pulses);
        chk("int_o_pat", int_o, model_pat(pulses, rot));
        if (rot && pulses == 3) chk("rot_code3", int_o, 32'h0078);
        if (pulses == 15) chk("code15_all_ones", int_o, 32'hFFFF);
        held = int_o;
        pulses++;
      end else if (busy) begin
        chk("int_o_hold", int_o, held);
      end
      start = (n == extra_at);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    e_err = 0; e_fec = 0; e_fev = 0;
    for (int k = 0; k < 16; k++) begin
      if (answer(k) != 4'(k)) begin
        if (!e_fev) begin e_fec = k; e_fev = 1; end
        e_err++;
      end
    end
    chk("done_latency", n, 16 * (LAT + 2));
    chk("enable_pulses", pulses, 16);
    chk("err_cnt", err_cnt, e_err);
    chk("first_err_code", first_err_code, e_fec);
    chk("first_err_vld", first_err_vld, e_fev);
    chk("pass", pass, e_err == 0);
    chk("done_busy", busy, 0);
    chk("done_int_o", int_o, 0);
    chk("done_cal_en", cal_en_o, 0);
  endtask

  typedef struct {
    bit          rot;
    bit          stk;
    logic [15:0] msk;
    int          extra;
    int          e_err;
    int          e_fec;
    bit          e_pass;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{rot: 1'b0, stk: 1'b0, msk: 16'h0000, extra: -1, e_err: 0,  e_fec: 0, e_pass: 1'b1};
    tbl[1] = '{rot: 1'b1, stk: 1'b0, msk: 16'h0000, extra: 20, e_err: 0,  e_fec: 0, e_pass: 1'b1};
    tbl[2] = '{rot: 1'b0, stk: 1'b0, msk: 16'h0080, extra: -1, e_err: 1,  e_fec: 7, e_pass: 1'b0};
    tbl[3] = '{rot: 1'b0, stk: 1'b1, msk: 16'h0000, extra: -1, e_err: 15, e_fec: 1, e_pass: 1'b0};
    tbl[4] = '{rot: 1'b0, stk: 1'b0, msk: 16'h0000, extra: -1, e_err: 0,  e_fec: 0, e_pass: 1'b1};

    stuck = 1'b0; fmask = '0;
    rst = 1'b1; start = 1'b0; rot_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_int_o", int_o, 0);
    chk("rst_cal_en", cal_en_o, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_fev", first_err_vld, 0);

    // rst and start together: reset wins
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_cal_en", cal_en_o, 0);

    for (int i = 0; i < 5; i++) begin
      run_sweep(tbl[i].rot, tbl[i].stk, tbl[i].msk, tbl[i].extra);
      chk("tbl_err_cnt", err_cnt, tbl[i].e_err);
      chk("tbl_first_err_code", first_err_code, tbl[i].e_fec);
      chk("tbl_pass", pass, tbl[i].e_pass);
    end

    // reset in the middle of a failing sweep, then a clean rerun
    stuck = 1'b1; fmask = '0; rot_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("mid_err_cnt", err_cnt, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_int_o", int_o, 0);
    chk("mid_rst_cal_en", cal_en_o, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_fev", first_err_vld, 0);
    run_sweep(1'b0, 1'b0, 16'h0000, -1);

    for (int i = 0; i < 6; i++) begin
      run_sweep(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                16'($urandom_range(0, 65535)), int'($urandom_range(1, 110)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
